// File: rtl/spi_wb_ctrl.sv
// spi_wb_ctrl: Wishbone master sequencer for the register port of the 8-bit
// SPI core. It programs SPCR/SPER after reset, then turns each command byte
// into one SPI transfer (write SPDR, wait for RX data, read SPDR) and returns
// the received byte on a one-cycle response pulse.
// Build option: define SPI_CTRL_IRQ_WAIT_EN to wait on wb_inta_i (with SPIE
// set and SPIF cleared after each transfer) instead of polling SPSR.RFEMPTY.
module spi_wb_ctrl #(
  parameter logic [7:0]  SPCR_INIT  = 8'h50,
  parameter logic [7:0]  SPER_INIT  = 8'h00,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic       init_done_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       wb_inta_i
);

  localparam logic [2:0] ADR_SPCR = 3'd0;
  localparam logic [2:0] ADR_SPSR = 3'd1;
  localparam logic [2:0] ADR_SPDR = 3'd2;
  localparam logic [2:0] ADR_SPER = 3'd3;
  localparam logic [7:0] POLL_MAX = 8'(POLL_LIMIT);

`ifdef SPI_CTRL_IRQ_WAIT_EN
  localparam logic [7:0] SPCR_WR = SPCR_INIT | 8'h80;
  typedef enum logic [2:0] {INIT_CR, INIT_ER, IDLE, WR_DR, WAIT, RD_DR, CLR_IF, RESP} state_t;
`else
  localparam logic [7:0] SPCR_WR = SPCR_INIT;
  typedef enum logic [2:0] {INIT_CR, INIT_ER, IDLE, WR_DR, WAIT, RD_DR, RESP} state_t;
  // The interrupt line is only consumed by the interrupt build.
  logic unused_inta;
  assign unused_inta = wb_inta_i;
`endif

  state_t     state, state_d;
  logic       cyc_q, cyc_d, we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d, done_q, done_d;

  // Bus request issued by the current state; the bus engine below runs it.
  logic       req, req_we;
  logic [2:0] req_adr;
  logic [7:0] req_dat;
  logic       acc_done;

  // An ack only counts while a cycle is actually open.
  assign acc_done = cyc_q & wb_ack_i;

  // Next-state and datapath decisions per state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_d = state;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    done_d  = done_q;
    req     = 1'b0;
    req_we  = 1'b0;
    req_adr = ADR_SPCR;
    req_dat = 8'h00;
    case (state)
      INIT_CR: begin
        req = 1'b1; req_we = 1'b1; req_adr = ADR_SPCR; req_dat = SPCR_WR;
        if (acc_done) state_d = INIT_ER;
      end
      INIT_ER: begin
        req = 1'b1; req_we = 1'b1; req_adr = ADR_SPER; req_dat = SPER_INIT;
        if (acc_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cmd_valid_i) begin
          byte_d  = cmd_data_i;
          cnt_d   = 8'd0;
          state_d = WR_DR;
        end
      end
      WR_DR: begin
        req = 1'b1; req_we = 1'b1; req_adr = ADR_SPDR; req_dat = byte_q;
        if (acc_done) state_d = WAIT;
      end
      WAIT: begin
`ifdef SPI_CTRL_IRQ_WAIT_EN
        // No bus traffic: count clock cycles until the core raises its interrupt.
        if (wb_inta_i) begin
          state_d = RD_DR;
        end else if (cnt_q + 8'd1 == POLL_MAX) begin
          rdata_d = 8'h00; err_d = 1'b1; state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`else
        // Poll SPSR; bit0 low means the receive FIFO holds the byte.
        req = 1'b1; req_adr = ADR_SPSR;
        if (acc_done) begin
          if (!wb_dat_i[0]) begin
            state_d = RD_DR;
          end else if (cnt_q + 8'd1 == POLL_MAX) begin
            rdata_d = 8'h00; err_d = 1'b1; state_d = RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`endif
      end
      RD_DR: begin
        req = 1'b1; req_adr = ADR_SPDR;
        if (acc_done) begin
          rdata_d = wb_dat_i;
          err_d   = 1'b0;
`ifdef SPI_CTRL_IRQ_WAIT_EN
          state_d = CLR_IF;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef SPI_CTRL_IRQ_WAIT_EN
      CLR_IF: begin
        req = 1'b1; req_we = 1'b1; req_adr = ADR_SPSR; req_dat = 8'h80;
        if (acc_done) state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = INIT_CR;
    endcase
  end

  // Bus engine: open a cycle on request, hold it until ack, then drop for one idle cycle.
  always_comb begin
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (cyc_q) begin
      if (wb_ack_i) cyc_d = 1'b0;
    end else if (req) begin
      cyc_d = 1'b1;
      we_d  = req_we;
      adr_d = req_adr;
      dat_d = req_dat;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= INIT_CR;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 3'd0;
      dat_q   <= 8'h00;
      cnt_q   <= 8'd0;
      byte_q  <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign cmd_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign rsp_data_o  = rdata_q;
  assign rsp_err_o   = err_q;
  assign init_done_o = done_q;

endmodule

// File: tb/tb_spi_wb_ctrl.sv
// tb_spi_wb_ctrl: scoreboard bench for spi_wb_ctrl (polling build).
// A Wishbone slave model checks every bus access against an expected-access
// queue; a response monitor checks every rsp_valid_o pulse against an
// expected-response queue. Both queues are filled by the stimulus from a
// transaction-level view of each command.
module tb_spi_wb_ctrl;

  localparam int LIMIT = 4;

  typedef struct packed { logic we; logic [2:0] adr; logic [7:0] dat; } bus_t;
  typedef struct packed { logic [7:0] dat; logic err; } rsp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_err, init_done;
  logic [7:0] cmd_data, rsp_data;
  logic       wb_cyc, wb_stb, wb_we, wb_ack, wb_inta;
  logic [2:0] wb_adr;
  logic [7:0] wb_dat_o, wb_dat_i;

  bus_t       bus_q[$];
  rsp_t       rsp_q[$];
  logic [7:0] spsr_q[$];
  logic [7:0] spdr_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_dly = 1;  // >0: fixed ack delay in cycles; 0: random 1..4 per access

  spi_wb_ctrl #(.SPCR_INIT(8'h50), .SPER_INIT(8'h00), .POLL_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .init_done_o(init_done),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_inta_i(wb_inta)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event seen or missed where the model disagrees", name);
  endtask

  task automatic push_init();
    bus_q.push_back({1'b1, 3'd0, 8'h50});
    bus_q.push_back({1'b1, 3'd3, 8'h00});
  endtask

  // Model one command: SPDR write, SPSR polls until RFEMPTY clears or the
  // limit is hit, then SPDR read and a response; then drive the handshake.
  task automatic send_cmd(input logic [7:0] b, input int nbusy,
                          input logic [7:0] busy_val, input logic [7:0] ready_val,
                          input logic [7:0] rx);
    int n;
    bus_q.push_back({1'b1, 3'd2, b});
    if (nbusy >= LIMIT) begin
      for (int i = 0; i < LIMIT; i++) begin
        bus_q.push_back({1'b0, 3'd1, 8'h00});
        spsr_q.push_back(busy_val);
      end
      rsp_q.push_back({8'h00, 1'b1});
    end else begin
      for (int i = 0; i < nbusy; i++) begin
        bus_q.push_back({1'b0, 3'd1, 8'h00});
        spsr_q.push_back(busy_val);
      end
      bus_q.push_back({1'b0, 3'd1, 8'h00});
      spsr_q.push_back(ready_val);
      bus_q.push_back({1'b0, 3'd2, 8'h00});
      spdr_q.push_back(rx);
      rsp_q.push_back({rx, 1'b0});
    end
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
  endtask

  task automatic send_random();
    send_cmd(8'($urandom), $urandom_range(0, 6), 8'($urandom) | 8'h01,
             8'($urandom) & 8'hFE, 8'($urandom));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0 || !cmd_ready) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) fail_now("drain_timeout");
  endtask

  task automatic release_and_init();
    int n;
    @(posedge clk); #3;
    push_init();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_access_cyc", 32'(wb_cyc), 32'd1);
    check("first_access_adr", 32'(wb_adr), 32'd0);
    n = 0;
    while (!init_done && n < 100) begin
      check("ready_low_during_init", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    if (!init_done) fail_now("init_timeout");
    check("ready_with_init_done", 32'(cmd_ready), 32'd1);
    check("init_writes_seen", 32'(bus_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"}, 32'(wb_cyc), 32'd0);
    check({tag, "_stb"}, 32'(wb_stb), 32'd0);
    check({tag, "_we"}, 32'(wb_we), 32'd0);
    check({tag, "_adr"}, 32'(wb_adr), 32'd0);
    check({tag, "_dat"}, 32'(wb_dat_o), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_init_done"}, 32'(init_done), 32'd0);
  endtask

  // Wishbone slave model: checks hold-stable and idle-cycle rules and
  // compares each completed access with the expected-access queue.
  initial begin : wb_slave
    bus_t cur, exp_b;
    int   wcnt, dly;
    bit   busy;
    wb_ack = 1'b0; wb_dat_i = 8'h00; busy = 1'b0; wcnt = 0; dly = 1; cur = '0;
    forever begin
      @(posedge clk); #1;
      wb_dat_i = 8'($urandom);
      if (!rst_n) begin
        wb_ack = 1'b0;
        busy   = 1'b0;
      end else if (wb_ack) begin
        wb_ack = 1'b0;
        busy   = 1'b0;
        check("cyc_low_after_ack", 32'(wb_cyc), 32'd0);
        check("stb_low_after_ack", 32'(wb_stb), 32'd0);
      end else if (wb_cyc) begin
        check("stb_with_cyc", 32'(wb_stb), 32'd1);
        if (!busy) begin
          busy = 1'b1;
          cur  = {wb_we, wb_adr, wb_dat_o};
          wcnt = 0;
          dly  = (ack_dly > 0) ? ack_dly : int'($urandom_range(1, 4));
        end else begin
          check("held_we", 32'(wb_we), 32'(cur.we));
          check("held_adr", 32'(wb_adr), 32'(cur.adr));
          check("held_dat", 32'(wb_dat_o), 32'(cur.dat));
        end
        if (wcnt == dly) begin
          wb_ack = 1'b1;
          if (bus_q.size() == 0) begin
            fail_now("bus_unexpected_access");
          end else begin
            exp_b = bus_q.pop_front();
            check("bus_we", 32'(cur.we), 32'(exp_b.we));
            check("bus_adr", 32'(cur.adr), 32'(exp_b.adr));
            if (exp_b.we) check("bus_wdata", 32'(cur.dat), 32'(exp_b.dat));
          end
          if (!cur.we && cur.adr == 3'd1)
            wb_dat_i = (spsr_q.size() != 0) ? spsr_q.pop_front() : 8'h05;
          else if (!cur.we && cur.adr == 3'd2)
            wb_dat_i = (spdr_q.size() != 0) ? spdr_q.pop_front() : 8'h00;
          else
            wb_dat_i = 8'h00;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Response monitor: pops the expected response for every rsp_valid_o cycle.
  initial begin : rsp_mon
    rsp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (prev) check("ready_after_rsp", 32'(cmd_ready), 32'd1);
        prev = rsp_valid;
        if (rsp_valid) begin
          check("ready_low_in_rsp", 32'(cmd_ready), 32'd0);
          if (rsp_q.size() == 0) begin
            fail_now("rsp_unexpected");
          end else begin
            e = rsp_q.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(e.dat));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Main stimulus sequence.
  initial begin : stim
    int lat;
    int n;
    cmd_valid = 1'b0; cmd_data = 8'h00; wb_inta = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_and_init();

    // Directed transfer, single-cycle ack: SPSR 05, 05, 04 then SPDR 3C.
    ack_dly = 1;
    send_cmd(8'hA5, 2, 8'h05, 8'h04, 8'h3C);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency_3_polls", 32'(lat), 32'(7 + 3 * 3));
    wait_done();

    // Timeout: SPSR stuck at 05 for the full poll budget.
    send_cmd(8'h5A, LIMIT, 8'h05, 8'h04, 8'h00);
    wait_done();

    // Same directed transfer with a slave that stretches every ack.
    ack_dly = 4;
    send_cmd(8'hA5, 2, 8'h05, 8'h04, 8'h3C);
    wait_done();

    // Random commands with random ack delays.
    ack_dly = 0;
    repeat (40) send_random();
    wait_done();

    // Reset while polling: the command is dropped and init repeats.
    ack_dly = 4;
    send_cmd(8'h11, 10, 8'h05, 8'h04, 8'h00);
    n = 0;
    while (!(wb_cyc && wb_adr == 3'd1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_wait_poll", 32'(wb_adr), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    bus_q.delete();
    rsp_q.delete();
    spsr_q.delete();
    spdr_q.delete();
    repeat (3) @(posedge clk);
    release_and_init();

    ack_dly = 0;
    repeat (10) send_random();
    wait_done();

    check("spsr_queue_drained", 32'(spsr_q.size()), 32'd0);
    check("spdr_queue_drained", 32'(spdr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
